// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load writebacks onto the single
// register file write port, with an in-order load queue and x0 dropping.
//
// Parameters
//   DEPTH       load queue entries (power of two, 2..8)
//   STARVE_MAX  cycles the queue head may wait before the ALU is stalled
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid/ready/rd/data     ALU writeback request (ready is combinational)
//   ld_valid/ready/rd/data      load writeback request
//   we_reg, wb_rd, wb_data      registered register file write port
//   q_count                     load queue occupancy
//   fwd_rs, fwd_hit, fwd_data   pending-write lookup
// Build option
//   WB_FWD_EN  enables the fwd_rs lookup; otherwise fwd_hit/fwd_data are 0
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [63:0]              alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [63:0]              ld_data,
    output logic                     we_reg,
    output logic [4:0]               wb_rd,
    output logic [63:0]              wb_data,
    output logic [$clog2(DEPTH):0]   q_count,
    input  logic [4:0]               fwd_rs,
    output logic                     fwd_hit,
    output logic [63:0]              fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_ent_t;

    wb_ent_t       q_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [AW-1:0] head_age;

    logic [PW-1:0]    q_off [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic             q_hit;
    logic             q_empty;
    logic             starve;
    logic             conflict;
    logic             alu_fire;
    logic             ld_fire;
    logic             alu_wr;
    logic             push;
    logic             pop;
    logic             sel_we;
    wb_ent_t          sel;

    assign q_count = cnt;
    assign q_empty = (cnt == '0);

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_off[i] = PW'(i) - rd_ptr;
            q_vld[i] = ({1'b0, q_off[i]} < cnt);
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_mem[i].rd == alu_rd)) begin
                q_hit = 1'b1;
            end
        end
    end

    // A same-cycle load counts as older, so it also blocks the ALU.
    assign conflict = (alu_rd != 5'd0) &&
                      (q_hit || (ld_valid && (ld_rd == alu_rd)));
    assign starve   = !q_empty && (head_age >= AGE_MAX);

    assign alu_ready = !rst && !starve && !conflict;
    assign ld_ready  = !rst && (cnt < FULL);

    assign alu_fire = alu_valid && alu_ready;
    assign ld_fire  = ld_valid && ld_ready;
    assign alu_wr   = alu_fire && (alu_rd != 5'd0);
    assign push     = ld_fire && (ld_rd != 5'd0);
    // An x0 ALU fire leaves the slot free for the queue head.
    assign pop      = !alu_wr && !q_empty;

    always_comb begin
        sel_we = 1'b0;
        sel    = '0;
        unique case (1'b1)
            alu_wr: begin
                sel_we   = 1'b1;
                sel.rd   = alu_rd;
                sel.data = alu_data;
            end
            pop: begin
                sel_we = 1'b1;
                sel    = q_mem[rd_ptr];
            end
            default: begin
                sel_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            head_age <= '0;
            we_reg   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (pop || q_empty) begin
                head_age <= '0;
            end else if (head_age < AGE_MAX) begin
                head_age <= head_age + 1'b1;
            end
            we_reg <= sel_we;
            if (sel_we) begin
                wb_rd   <= sel.rd;
                wb_data <= sel.data;
            end
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] age_idx [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k] = rd_ptr + PW'(k);
        end
    end

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rs != 5'd0) begin
            if (we_reg && (wb_rd == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (q_vld[age_idx[k]] &&
                    (q_mem[age_idx[k]].rd == fwd_rs)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = q_mem[age_idx[k]].data;
                end
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^fwd_rs;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of the writeback arbiter.
// Expected values are hand-derived cycle by cycle.
module tb_regfile_wb_arbiter;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        we_reg;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [2:0]  q_count;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [63:0] fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .we_reg(we_reg), .wb_rd(wb_rd), .wb_data(wb_data),
        .q_count(q_count),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
    endtask

    initial begin
        idle();
        fwd_rs = '0;
        rst    = 1'b1;
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_ld_ready", ld_ready, 0);
        step();
        step();
        check("rst_we", we_reg, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_qcount", q_count, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_data", fwd_data, 0);
        rst = 1'b0;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5; alu_data = 64'hAAAA;
        #1;
        check("alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("alu_we", we_reg, 1);
        check("alu_rd", wb_rd, 5);
        check("alu_data", wb_data, 64'hAAAA);
        step();
        check("alu_we_off", we_reg, 0);
        check("alu_rd_hold", wb_rd, 5);

        // x0 drops
        alu_valid = 1'b1; alu_rd = 0; alu_data = 64'h1234;
        step();
        alu_valid = 1'b0;
        check("x0_alu_we", we_reg, 0);
        ld_valid = 1'b1; ld_rd = 0; ld_data = 64'h55;
        #1;
        check("x0_ld_ready", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        check("x0_ld_qcount", q_count, 0);
        step();
        check("x0_ld_we", we_reg, 0);

        // fill the queue while the ALU streams to rd 9
        alu_valid = 1'b1; alu_rd = 9; alu_data = 64'h99;
        ld_valid = 1'b1; ld_rd = 1; ld_data = 64'h101;
        #1;
        check("fill_alu_ready0", alu_ready, 1);
        check("fill_ld_ready0", ld_ready, 1);
        for (int i = 1; i <= 4; i++) begin
            ld_rd   = 5'(i);
            ld_data = 64'h100 + 64'(i);
            step();
        end
        ld_valid = 1'b0;
        #1;
        check("fill_qcount4", q_count, 4);
        check("fill_ld_full", ld_ready, 0);
        check("fill_alu_age3", alu_ready, 1);
        check("fill_wb_alu", wb_rd, 9);
        step();
        check("fill_starve", alu_ready, 0);
        step();
        check("fill_l1_we", we_reg, 1);
        check("fill_l1_rd", wb_rd, 1);
        check("fill_l1_data", wb_data, 64'h101);
        check("fill_qcount3", q_count, 3);
        check("fill_alu_resume", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("fill_alu_rd", wb_rd, 9);
        step();
        check("fill_l2_rd", wb_rd, 2);
        check("fill_l2_data", wb_data, 64'h102);
        step();
        check("fill_l3_rd", wb_rd, 3);
        step();
        check("fill_l4_rd", wb_rd, 4);
        check("fill_l4_data", wb_data, 64'h104);
        check("fill_qcount0", q_count, 0);
        step();
        check("fill_idle_we", we_reg, 0);

        // WAW: queued load to rd 7 blocks ALU rd 7
        ld_valid = 1'b1; ld_rd = 7; ld_data = 64'h77;
        step();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 7; alu_data = 64'hA7;
        #1;
        check("waw_stall", alu_ready, 0);
        step();
        check("waw_ld_rd", wb_rd, 7);
        check("waw_ld_data", wb_data, 64'h77);
        check("waw_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("waw_alu_we", we_reg, 1);
        check("waw_alu_data", wb_data, 64'hA7);
        step();

        // same-cycle load and ALU to rd 3
        ld_valid = 1'b1; ld_rd = 3; ld_data = 64'h33;
        alu_valid = 1'b1; alu_rd = 3; alu_data = 64'hC3;
        #1;
        check("sim_alu_stall", alu_ready, 0);
        check("sim_ld_ready", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        #1;
        check("sim_alu_stall2", alu_ready, 0);
        step();
        check("sim_ld_data", wb_data, 64'h33);
        check("sim_alu_go", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("sim_alu_rd", wb_rd, 3);
        check("sim_alu_data", wb_data, 64'hC3);
        step();

        // ALU to x0 frees the slot for the queue head
        alu_valid = 1'b1; alu_rd = 11; alu_data = 64'hB11;
        ld_valid = 1'b1; ld_rd = 12; ld_data = 64'hC12;
        step();
        ld_valid = 1'b0;
        alu_rd = 0; alu_data = 64'h0;
        check("x0slot_alu_rd", wb_rd, 11);
        #1;
        check("x0slot_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("x0slot_pop_rd", wb_rd, 12);
        check("x0slot_pop_data", wb_data, 64'hC12);
        step();

        // forwarding, then reset mid-operation
        alu_valid = 1'b1; alu_rd = 10; alu_data = 64'hAA10;
        ld_valid = 1'b1; ld_rd = 6; ld_data = 64'h11;
        step();
        ld_data = 64'h22;
        #1;
        check("fwd_alu_ready", alu_ready, 1);
        step();
        ld_valid = 1'b0;
        fwd_rs = 6;
        #1;
        check("fwd_qcount", q_count, 2);
        check("fwd_hit6", fwd_hit, FWD ? 1 : 0);
        check("fwd_data6", fwd_data, FWD ? 64'h22 : 64'h0);
        fwd_rs = 10;
        #1;
        check("fwd_hit_out", fwd_hit, FWD ? 1 : 0);
        check("fwd_data_out", fwd_data, FWD ? 64'hAA10 : 64'h0);
        fwd_rs = 0;
        #1;
        check("fwd_x0", fwd_hit, 0);
        fwd_rs = 6;
        rst = 1'b1;
        #1;
        check("mid_rst_alu_ready", alu_ready, 0);
        check("mid_rst_ld_ready", ld_ready, 0);
        step();
        check("mid_rst_qcount", q_count, 0);
        check("mid_rst_we", we_reg, 0);
        check("mid_rst_fwd_hit", fwd_hit, 0);
        check("mid_rst_fwd_data", fwd_data, 0);
        rst = 1'b0;
        idle();
        step();
        check("post_rst_we", we_reg, 0);
        check("post_rst_qcount", q_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32 x 64-bit integer register file. Merges two writeback sources, single-cycle ALU results and variable-latency load data, onto the register file's single write port (`we_reg`, `rd`, `dataW`). It sits between execute/memory and the register file. It buffers loads in a small in-order queue, drops x0 writes, and stalls the ALU to prevent write-after-write reordering and load starvation.

## Interface
- `DEPTH`, 4: load queue entries, power of two, 2..8
- `STARVE_MAX`, 4: cycles the queue head may wait before the ALU is stalled
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle (combinational)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  64  ALU result
- `ld_valid`  in  1  load writeback request
- `ld_ready`  out  1  load request accepted this cycle
- `ld_rd`  in  5  load destination register
- `ld_data`  in  64  load data
- `we_reg`  out  1  register file write enable (registered)
- `wb_rd`  out  5  register file write address (registered)
- `wb_data`  out  64  register file write data (registered)
- `q_count`  out  $clog2(DEPTH)+1  queue occupancy
- `fwd_rs`  in  5  forwarding lookup address (used only with `WB_FWD_EN`)
- `fwd_hit`  out  1  lookup matched a pending write
- `fwd_data`  out  64  data of the matching pending write

## Operation
- A request fires on a cycle where valid and ready are both high.
- `ld_ready = (q_count < DEPTH)`.
  - The full check ignores any same-cycle pop.
  - A load fire with `ld_rd != 0` pushes to the queue tail.
  - A load fire with `ld_rd == 0` is consumed and discarded.
- `alu_ready = !starve && !conflict`.
  - `starve`: the queue is non-empty and `head_age >= STARVE_MAX`.
  - `conflict`: `alu_rd != 0` and `alu_rd` equals the rd of any valid queue entry, or `ld_valid && ld_rd == alu_rd`.
  - A load is always treated as older than a same-cycle ALU result.
- Write-slot selection each cycle, in priority order:
  1. ALU fire with `alu_rd != 0`: load `we_reg=1`, `wb_rd=alu_rd`, `wb_data=alu_data`.
  2. Queue non-empty: pop the head and load its rd/data with `we_reg=1`.
  3. Otherwise: `we_reg=0`.
  - An ALU fire with `alu_rd == 0` frees the slot for a queue pop.
- Push and pop in the same cycle are allowed. `q_count` is unchanged when both occur.
- `head_age`:
  - Increments, saturating at `STARVE_MAX`, each cycle the queue is non-empty and no pop occurs.
  - Clears on pop or when the queue is empty.
- Queue pointers wrap modulo `DEPTH`. Entries leave strictly in FIFO order.
- The ALU has no queue. A stalled ALU holds `alu_valid`, `alu_rd` and `alu_data` stable until it fires.

## Timing
- ALU fire in cycle c: `we_reg` high in cycle c+1.
- Load fire in cycle c: earliest `we_reg` in cycle c+2. It is later if the ALU holds the slot, bounded by `STARVE_MAX` plus older entries.
- `wb_rd` and `wb_data` hold their last value when `we_reg=0`. They are valid only with `we_reg`.
- On reset:
  - `we_reg=0`, `wb_rd=0`, `wb_data=0`, `q_count=0`.
  - Queue empty, `head_age=0`, `fwd_hit=0`, `fwd_data=0`.
  - `ld_ready=0` and `alu_ready=0` while `rst` is high.
- Reset mid-operation discards all queued loads. The load source must reissue them.
- Throughput: one register file write per cycle.

## Configuration
- `WB_FWD_EN` defined:
  - Combinational lookup of `fwd_rs` against all valid queue entries plus the output register when `we_reg=1`.
  - The youngest match wins, with priority queue tail > ... > head > output register.
  - `fwd_rs == 0` never hits.
  - `fwd_hit` and `fwd_data` give the result.
- `WB_FWD_EN` undefined:
  - `fwd_hit=0` and `fwd_data=0` constantly.
  - `fwd_rs` is ignored.
  - No comparator logic is generated.

## Test plan
- **ALU only.** `alu_rd=5`, `alu_data=0xAAAA` in cycle 1 -> cycle 2: `we_reg=1`, `wb_rd=5`, `wb_data=0xAAAA`.
- **x0 drop.**
  - ALU `rd=0` -> `we_reg` stays 0.
  - Load `rd=0` -> `q_count` stays 0.
- **Loads fill the queue (DEPTH=4).**
  - Hold `alu_valid` with `rd=9` and push 4 loads to rd 1..4 -> `ld_ready=0` at `q_count=4`.
  - `alu_ready` drops after 4 cycles of head wait.
  - Loads then write in order 1,2,3,4.
- **WAW conflict.**
  - Load `rd=7` queued, then ALU `rd=7` -> `alu_ready=0` until the rd=7 pop.
  - The ALU write follows one cycle after the load write.
- **Simultaneous events.**
  - Same-cycle load `rd=3` and ALU `rd=3` -> ALU stalled, load accepted.
  - Then: load writes rd=3, ALU writes rd=3 the next cycle.
- **Reset and forwarding (`WB_FWD_EN`).**
  - Two loads to rd 6 queued with data 0x11 then 0x22, `fwd_rs=6` -> `fwd_hit=1`, `fwd_data=0x22`.
  - Assert `rst` -> `q_count=0`, `fwd_hit=0`, `we_reg=0` next cycle.
